// File: rtl/riscv_dcache_assoc.sv
`timescale 1ns/1ps
// riscv_dcache_assoc
//   N-way set-associative, write-back, write-allocate L1 data cache between the
//   core MEM stage and a line-wide DDR interface. Tag, valid/dirty, data arrays,
//   round-robin victim pointers and the miss FSM all live in this block.
//
// Ports
//   i_riscv_dcache_clk / _rst       clock, asynchronous active-high reset
//   i_riscv_dcache_globstall        pipeline stall, blocks new requests
//   i_riscv_dcache_cpu_wren/_rden   store / load request (both = store)
//   i_riscv_dcache_store_src        access size: byte, half, word, double
//   i_riscv_dcache_phys_addr        naturally aligned byte address
//   i_riscv_dcache_cpu_data_in      right-justified store data
//   i_riscv_dcache_mem_ready        memory finished current line transfer
//   i_riscv_dcache_mem_data_out     fill line
//   o_riscv_dcache_mem_data_in      writeback line
//   o_riscv_dcache_mem_addr         line address {tag,index}
//   o_riscv_dcache_mem_wren/_rden   writeback / fill request (level)
//   o_riscv_dcache_cpu_data_out     aligned doubleword of the hit line
//   o_riscv_dcache_cpu_stall        request not yet complete
//
// Optional build macro RISCV_DCACHE_PERF_CNT_EN adds o_riscv_dcache_hit_cnt and
// o_riscv_dcache_miss_cnt (32-bit wrapping event counters).
module riscv_dcache_assoc #(
  parameter int DATA_WIDTH = 128,
  parameter int CACHE_SIZE = 4096,
  parameter int WAYS       = 2,
  parameter int MEM_SIZE   = 128 * (2 ** 20),
  parameter int DATAPBLOCK = DATA_WIDTH / 8,
  parameter int SETS       = CACHE_SIZE / (DATAPBLOCK * WAYS),
  parameter int ADDR       = $clog2(MEM_SIZE),
  parameter int BYTE_OFF   = $clog2(DATAPBLOCK),
  parameter int INDEX      = $clog2(SETS),
  parameter int TAG        = ADDR - BYTE_OFF - INDEX
) (
  input  logic                  i_riscv_dcache_clk,
  input  logic                  i_riscv_dcache_rst,
  input  logic                  i_riscv_dcache_globstall,
  input  logic                  i_riscv_dcache_cpu_wren,
  input  logic                  i_riscv_dcache_cpu_rden,
  input  logic [1:0]            i_riscv_dcache_store_src,
  input  logic [ADDR-1:0]       i_riscv_dcache_phys_addr,
  input  logic [63:0]           i_riscv_dcache_cpu_data_in,
  input  logic                  i_riscv_dcache_mem_ready,
  input  logic [DATA_WIDTH-1:0] i_riscv_dcache_mem_data_out,
  output logic [DATA_WIDTH-1:0] o_riscv_dcache_mem_data_in,
  output logic [TAG+INDEX-1:0]  o_riscv_dcache_mem_addr,
  output logic                  o_riscv_dcache_mem_wren,
  output logic                  o_riscv_dcache_mem_rden,
  output logic [63:0]           o_riscv_dcache_cpu_data_out,
  output logic                  o_riscv_dcache_cpu_stall
`ifdef RISCV_DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]           o_riscv_dcache_hit_cnt,
  output logic [31:0]           o_riscv_dcache_miss_cnt
`endif
);

  localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] ALLOCATE  = 2'd2;

  // Clears the byte offset inside a doubleword, leaving the doubleword bit position.
  localparam logic [BYTE_OFF+2:0] DW_MASK = ~(BYTE_OFF + 3)'(32'd63);

  logic [1:0]            state;
  logic [WAY_BITS-1:0]   miss_way;

  logic [TAG-1:0]        tag_mem  [WAYS][SETS];
  logic [DATA_WIDTH-1:0] data_mem [WAYS][SETS];
  logic [WAYS-1:0]       valid    [SETS];
  logic [WAYS-1:0]       dirty    [SETS];
  logic [WAY_BITS-1:0]   rr_ptr   [SETS];

  logic [BYTE_OFF-1:0]   byte_off;
  logic [INDEX-1:0]      index;
  logic [TAG-1:0]        tag;
  logic                  req;
  logic                  is_store;
  logic                  is_load;

  logic [WAYS-1:0]       way_hit;
  logic [WAYS-1:0]       way_inv;
  logic                  hit;
  logic [WAY_BITS-1:0]   hit_way;
  logic [WAY_BITS-1:0]   inv_way;
  logic [WAY_BITS-1:0]   victim;
  logic [WAY_BITS-1:0]   rr_next;

  logic [7:0]            lane;
  logic [DATAPBLOCK-1:0] byte_mask;
  logic [DATA_WIDTH-1:0] store_data;
  logic [DATA_WIDTH-1:0] hit_line;
  logic [DATA_WIDTH-1:0] merged_line;
  logic [BYTE_OFF+2:0]   dw_pos;
  logic [63:0]           load_dw;

  logic                  idle_req;
  logic                  store_hit;
  logic                  fill_done;

  assign byte_off = i_riscv_dcache_phys_addr[BYTE_OFF-1:0];
  assign index    = i_riscv_dcache_phys_addr[BYTE_OFF+INDEX-1:BYTE_OFF];
  assign tag      = i_riscv_dcache_phys_addr[ADDR-1:ADDR-TAG];

  assign req      = (i_riscv_dcache_cpu_rden | i_riscv_dcache_cpu_wren) & ~i_riscv_dcache_globstall;
  assign is_store = i_riscv_dcache_cpu_wren;
  assign is_load  = i_riscv_dcache_cpu_rden & ~i_riscv_dcache_cpu_wren;

  assign idle_req  = (state == IDLE) & req;
  assign store_hit = idle_req & hit & is_store;
  assign fill_done = (state == ALLOCATE) & i_riscv_dcache_mem_ready;

  // Per-way tag compare and invalid detection for the addressed set.
  for (genvar g = 0; g < WAYS; g++) begin : g_way
    assign way_hit[g] = valid[index][g] & (tag_mem[g][index] == tag);
    assign way_inv[g] = ~valid[index][g];
  end

  // Hit way and lowest-index invalid way; descending scan so the lowest index wins.
  always_comb begin
    hit_way = '0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_way = way_hit[w] ? WAY_BITS'(w) : hit_way;
      inv_way = way_inv[w] ? WAY_BITS'(w) : inv_way;
    end
    hit     = |way_hit;
    victim  = (|way_inv) ? inv_way : rr_ptr[index];
    rr_next = (rr_ptr[index] == WAY_BITS'(WAYS - 1)) ? '0 : rr_ptr[index] + WAY_BITS'(1);
  end

  // Byte-lane mask and shifted store data, merged over the hit line.
  always_comb begin
    case (i_riscv_dcache_store_src)
      2'b00:   lane = 8'h01;
      2'b01:   lane = 8'h03;
      2'b10:   lane = 8'h0F;
      2'b11:   lane = 8'hFF;
      default: lane = 8'h01;
    endcase
    byte_mask   = DATAPBLOCK'(lane) << byte_off;
    store_data  = DATA_WIDTH'(i_riscv_dcache_cpu_data_in) << {byte_off, 3'b000};
    hit_line    = data_mem[hit_way][index];
    merged_line = hit_line;
    for (int b = 0; b < DATAPBLOCK; b++) begin
      merged_line[b*8 +: 8] = byte_mask[b] ? store_data[b*8 +: 8] : hit_line[b*8 +: 8];
    end
    dw_pos  = {byte_off, 3'b000} & DW_MASK;
    load_dw = 64'(hit_line >> dw_pos);
  end

  // Miss FSM; the victim way is captured on the IDLE->miss transition.
  always_ff @(posedge i_riscv_dcache_clk or posedge i_riscv_dcache_rst) begin
    if (i_riscv_dcache_rst) begin
      state    <= IDLE;
      miss_way <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !hit) begin
            miss_way <= victim;
            state    <= (valid[index][victim] && dirty[index][victim]) ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          if (i_riscv_dcache_mem_ready) begin
            state <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (i_riscv_dcache_mem_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Valid/dirty bits and round-robin pointers; the pointer only moves when a valid line is replaced.
  always_ff @(posedge i_riscv_dcache_clk or posedge i_riscv_dcache_rst) begin
    if (i_riscv_dcache_rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid[s]  <= '0;
        dirty[s]  <= '0;
        rr_ptr[s] <= '0;
      end
    end else if (store_hit) begin
      dirty[index][hit_way] <= 1'b1;
    end else if (fill_done) begin
      valid[index][miss_way] <= 1'b1;
      dirty[index][miss_way] <= 1'b0;
      if (valid[index][miss_way]) begin
        rr_ptr[index] <= rr_next;
      end
    end
  end

  // Tag and data arrays (not reset): store-hit merge or line fill.
  always_ff @(posedge i_riscv_dcache_clk) begin
    if (store_hit) begin
      data_mem[hit_way][index] <= merged_line;
    end else if (fill_done) begin
      data_mem[miss_way][index] <= i_riscv_dcache_mem_data_out;
      tag_mem[miss_way][index]  <= tag;
    end
  end

  // Memory-side outputs follow the FSM state, so reset drops them immediately.
  always_comb begin
    o_riscv_dcache_mem_wren    = 1'b0;
    o_riscv_dcache_mem_rden    = 1'b0;
    o_riscv_dcache_mem_addr    = '0;
    o_riscv_dcache_mem_data_in = '0;
    case (state)
      WRITEBACK: begin
        o_riscv_dcache_mem_wren    = 1'b1;
        o_riscv_dcache_mem_addr    = {tag_mem[miss_way][index], index};
        o_riscv_dcache_mem_data_in = data_mem[miss_way][index];
      end
      ALLOCATE: begin
        o_riscv_dcache_mem_rden = 1'b1;
        o_riscv_dcache_mem_addr = {tag, index};
      end
      default: begin
        o_riscv_dcache_mem_wren = 1'b0;
      end
    endcase
  end

  // CPU-side outputs: same-cycle load data on hit, stall on miss or while a miss is in flight.
  always_comb begin
    o_riscv_dcache_cpu_stall    = ~i_riscv_dcache_rst & ((state != IDLE) | (req & ~hit));
    o_riscv_dcache_cpu_data_out = (~i_riscv_dcache_rst & idle_req & is_load & hit) ? load_dw : 64'd0;
  end

`ifdef RISCV_DCACHE_PERF_CNT_EN
  logic retry;

  // Event counters; a request that completes after its own fill is not counted as a hit.
  always_ff @(posedge i_riscv_dcache_clk or posedge i_riscv_dcache_rst) begin
    if (i_riscv_dcache_rst) begin
      retry                   <= 1'b0;
      o_riscv_dcache_hit_cnt  <= 32'd0;
      o_riscv_dcache_miss_cnt <= 32'd0;
    end else begin
      if (fill_done) begin
        retry <= 1'b1;
      end else if (idle_req && hit) begin
        retry <= 1'b0;
      end
      if (idle_req && hit && !retry) begin
        o_riscv_dcache_hit_cnt <= o_riscv_dcache_hit_cnt + 32'd1;
      end
      if (idle_req && !hit) begin
        o_riscv_dcache_miss_cnt <= o_riscv_dcache_miss_cnt + 32'd1;
      end
    end
  end
`else
  // Default build: no performance counters.
`endif

endmodule

// File: tb/tb_riscv_dcache_assoc.sv
`timescale 1ns/1ps
module tb_riscv_dcache_assoc;

  localparam int DW   = 128;
  localparam int ADDR = 27;
  localparam int LA   = 23;
  localparam int SETS = 128;
  localparam int WAYS = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            globstall;
  logic            wren;
  logic            rden;
  logic [1:0]      src;
  logic [ADDR-1:0] addr;
  logic [63:0]     wdata;
  logic            mem_ready;
  logic [DW-1:0]   mem_dout;
  logic [DW-1:0]   mem_din;
  logic [LA-1:0]   mem_addr;
  logic            mem_wren;
  logic            mem_rden;
  logic [63:0]     cpu_dout;
  logic            stall;
`ifdef RISCV_DCACHE_PERF_CNT_EN
  logic [31:0]     hit_cnt;
  logic [31:0]     miss_cnt;
`endif

  riscv_dcache_assoc dut (
    .i_riscv_dcache_clk          (clk),
    .i_riscv_dcache_rst          (rst),
    .i_riscv_dcache_globstall    (globstall),
    .i_riscv_dcache_cpu_wren     (wren),
    .i_riscv_dcache_cpu_rden     (rden),
    .i_riscv_dcache_store_src    (src),
    .i_riscv_dcache_phys_addr    (addr),
    .i_riscv_dcache_cpu_data_in  (wdata),
    .i_riscv_dcache_mem_ready    (mem_ready),
    .i_riscv_dcache_mem_data_out (mem_dout),
    .o_riscv_dcache_mem_data_in  (mem_din),
    .o_riscv_dcache_mem_addr     (mem_addr),
    .o_riscv_dcache_mem_wren     (mem_wren),
    .o_riscv_dcache_mem_rden     (mem_rden),
    .o_riscv_dcache_cpu_data_out (cpu_dout),
    .o_riscv_dcache_cpu_stall    (stall)
`ifdef RISCV_DCACHE_PERF_CNT_EN
    ,
    .o_riscv_dcache_hit_cnt      (hit_cnt),
    .o_riscv_dcache_miss_cnt     (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // golden: what the CPU must observe; backing: what DDR holds.
  logic [DW-1:0] golden  [int];
  logic [DW-1:0] backing [int];
  int  m_tag   [SETS][WAYS];
  bit  m_valid [SETS][WAYS];
  bit  m_dirty [SETS][WAYS];
  int  m_rr    [SETS];

  typedef struct {
    bit            wr;
    logic [LA-1:0] a;
    logic [DW-1:0] d;
  } mem_txn_t;

  mem_txn_t      exp_mem_q [$];
  logic [63:0]   exp_load_q [$];
  bit            block_ready = 1'b0;

  function automatic logic [DW-1:0] init_line(input int la);
    return {la * 32'h9E3779B1, ~la, la ^ 32'h5A5A5A5A, la * 32'h01000193 + 32'd7};
  endfunction

  function automatic logic [DW-1:0] get_g(input int la);
    return golden.exists(la) ? golden[la] : init_line(la);
  endfunction

  function automatic logic [DW-1:0] get_b(input int la);
    return backing.exists(la) ? backing[la] : init_line(la);
  endfunction

  task automatic model_reset();
    golden = backing;
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_tag[s][w]   = 0;
      end
    end
  endtask

  // Predicts one access: queues expected memory traffic and load data, updates model state.
  task automatic model_access(input bit st, input logic [1:0] sz, input logic [ADDR-1:0] a,
                              input logic [63:0] d, output bit hit);
    int la, idx, tg, way, off;
    logic [DW-1:0] line;
    mem_txn_t t;
    la = int'(a >> 4);
    idx = la % SETS;
    tg = la / SETS;
    way = -1;
    hit = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (m_valid[idx][w] && m_tag[idx][w] == tg) begin
        way = w;
        hit = 1'b1;
      end
    end
    if (!hit) begin
      for (int w = WAYS - 1; w >= 0; w--) begin
        if (!m_valid[idx][w]) way = w;
      end
      if (way < 0) begin
        way = m_rr[idx];
        m_rr[idx] = (m_rr[idx] + 1) % WAYS;
      end
      if (m_valid[idx][way] && m_dirty[idx][way]) begin
        t.wr = 1'b1;
        t.a  = LA'(m_tag[idx][way] * SETS + idx);
        t.d  = get_g(m_tag[idx][way] * SETS + idx);
        exp_mem_q.push_back(t);
      end
      t.wr = 1'b0;
      t.a  = LA'(la);
      t.d  = '0;
      exp_mem_q.push_back(t);
      m_tag[idx][way]   = tg;
      m_valid[idx][way] = 1'b1;
      m_dirty[idx][way] = 1'b0;
    end
    line = get_g(la);
    if (st) begin
      off = int'(a[3:0]);
      for (int i = 0; i < (1 << sz); i++) line[(off + i) * 8 +: 8] = d[i * 8 +: 8];
      golden[la] = line;
      m_dirty[idx][way] = 1'b1;
    end else begin
      exp_load_q.push_back(line[int'(a[3]) * 64 +: 64]);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input bit st, input logic [1:0] sz, input logic [ADDR-1:0] a,
                        input logic [63:0] d, input int gs_cycles);
    bit hit;
    int n;
    model_access(st, sz, a, d, hit);
    @(posedge clk);
    #1;
    wren      = st;
    rden      = st ? 1'($urandom_range(0, 1)) : 1'b1;
    src       = sz;
    addr      = a;
    wdata     = d;
    globstall = (gs_cycles > 0);
    for (int i = 0; i < gs_cycles; i++) begin
      @(negedge clk);
      check("gs_no_stall", stall, 1'b0);
      check("gs_no_rden", mem_rden, 1'b0);
      @(posedge clk);
      #1;
    end
    globstall = 1'b0;
    @(negedge clk);
    check("first_cycle_stall", stall, !hit);
    n = 0;
    while (stall && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL req_timeout addr=%h still stalled after %0d cycles", a, n);
    end
    @(posedge clk);
    #1;
    wren = 1'b0;
    rden = 1'b0;
  endtask

  // ---------------- load monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (rden && !wren && !globstall && !stall) begin
        if (exp_load_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL load_unexpected actual=%h expected=none", cpu_dout);
        end else begin
          check("load_data", cpu_dout, exp_load_q.pop_front());
        end
      end else if (stall) begin
        check("data_zero_in_stall", cpu_dout, 64'd0);
      end
    end
  end

  // ---------------- memory responder / monitor ----------------
  initial begin
    mem_txn_t e;
    bit isw;
    int dly, k;
    mem_ready = 1'b0;
    mem_dout  = '0;
    forever begin
      @(negedge clk);
      if (!rst && (mem_rden || mem_wren)) begin
        isw = mem_wren;
        if (exp_mem_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mem_unexpected actual wr=%0d addr=%h expected=none", isw, mem_addr);
        end else begin
          e = exp_mem_q.pop_front();
          check("mem_kind", isw, e.wr);
          check("mem_addr", mem_addr, e.a);
          if (isw) begin
            check("wb_data", mem_din, e.d);
            backing[int'(e.a)] = e.d;
          end
        end
        dly = $urandom_range(0, 3);
        k = 0;
        while ((block_ready || k < dly) && !rst && k < 500) begin
          @(negedge clk);
          k++;
        end
        if (!rst) begin
          if (!isw) mem_dout = get_b(int'(mem_addr));
          mem_ready = 1'b1;
          @(negedge clk);
          mem_ready = 1'b0;
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [ADDR-1:0] a;
    logic [1:0] sz;
    int tg, idx, off, n;
    int tags [5] = '{0, 1, 2, 3, 5};

    model_reset();
    rst = 1'b1;
    globstall = 1'b0;
    wren = 1'b0;
    rden = 1'b1;
    src = 2'b11;
    addr = 27'h100;
    wdata = 64'd0;
    repeat (2) @(negedge clk);
    check("rst_stall", stall, 1'b0);
    check("rst_mem_wren", mem_wren, 1'b0);
    check("rst_mem_rden", mem_rden, 1'b0);
    check("rst_mem_addr", mem_addr, 23'd0);
    check("rst_mem_din", mem_din, 128'd0);
    check("rst_cpu_dout", cpu_dout, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rden = 1'b0;

    // Fill, store-hit byte merge, read back the merged doubleword.
    do_req(1'b0, 2'b11, 27'h100, 64'd0, 0);
    do_req(1'b1, 2'b00, 27'h109, 64'h00000000000000AB, 0);
    do_req(1'b0, 2'b11, 27'h108, 64'd0, 0);

    // Set 0: tags A=1, B=2, dirty A, C evicts A with writeback, D evicts clean B, A again evicts C.
    do_req(1'b0, 2'b11, 27'h0800, 64'd0, 0);
    do_req(1'b0, 2'b11, 27'h1000, 64'd0, 0);
    do_req(1'b1, 2'b11, 27'h0800, 64'h0123456789ABCDEF, 0);
    do_req(1'b0, 2'b11, 27'h1800, 64'd0, 0);
    do_req(1'b0, 2'b11, 27'h2000, 64'd0, 0);
    do_req(1'b0, 2'b10, 27'h0804, 64'd0, 0);

    // Global stall holds off a miss until released.
    do_req(1'b0, 2'b11, 27'h4008, 64'd0, 3);

    // Reset while a fill is outstanding.
    begin
      mem_txn_t t;
      t.wr = 1'b0;
      t.a  = 23'h3F;
      t.d  = '0;
      exp_mem_q.push_back(t);
    end
    block_ready = 1'b1;
    @(posedge clk);
    #1;
    rden = 1'b1;
    wren = 1'b0;
    src = 2'b11;
    addr = 27'h3F0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_rden && n < 20);
    check("pre_rst_rden", mem_rden, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_rden", mem_rden, 1'b0);
    check("async_rst_stall", stall, 1'b0);
    rden = 1'b0;
    block_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    do_req(1'b0, 2'b11, 27'h3F0, 64'd0, 0);

    // Randomized traffic over a few sets and tags to force evictions.
    for (int i = 0; i < 300; i++) begin
      tg  = tags[$urandom_range(0, 4)];
      idx = $urandom_range(0, 3);
      sz  = 2'($urandom_range(0, 3));
      off = $urandom_range(0, 15) & ~((1 << sz) - 1);
      a   = ADDR'((tg * SETS + idx) * 16 + off);
      do_req(1'($urandom_range(0, 1)), sz, a, {$urandom, $urandom},
             ($urandom_range(0, 9) == 0) ? 2 : 0);
    end

    repeat (3) @(negedge clk);
    check("mem_q_drained", exp_mem_q.size(), 0);
    check("load_q_drained", exp_load_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
